// File: rtl/mmio_voice_ctrl.sv
// Memory-mapped voice controller: per-voice frequency words, note lifecycle FSMs with a timed
// release phase, plus free-running cycle/instruction counters, all behind a simple load/store bus.
module mmio_voice_ctrl #(
    parameter int unsigned NUM_VOICES     = 4,
    parameter int unsigned FCW_WIDTH      = 24,
    parameter int unsigned RELEASE_CYCLES = 1024
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic [15:0]                     addr,
    input  logic [2:0]                      mmap_sel,
    input  logic [31:0]                     wdata,
    input  logic                            inst_inc,
    output logic [31:0]                     rdata,
    output logic                            rvalid,
    output logic [NUM_VOICES*FCW_WIDTH-1:0] fcw,
    output logic [NUM_VOICES-1:0]           note_start,
    output logic [NUM_VOICES-1:0]           note_release,
    output logic [NUM_VOICES-1:0]           note_reset,
    output logic [NUM_VOICES-1:0]           voice_active,
    output logic                            synth_rst
);

    localparam int unsigned CntW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(RELEASE_CYCLES - 1);

    localparam logic [15:0] AddrCycle    = 16'h0010;
    localparam logic [15:0] AddrInst     = 16'h0014;
    localparam logic [15:0] AddrCntClr   = 16'h0018;
    localparam logic [15:0] AddrSynthRst = 16'h0100;

    localparam logic [4:0] OffFcw      = 5'h00;
    localparam logic [4:0] OffStart    = 5'h04;
    localparam logic [4:0] OffRelease  = 5'h08;
    localparam logic [4:0] OffFinished = 5'h0C;
    localparam logic [4:0] OffReset    = 5'h10;
    localparam logic [4:0] OffState    = 5'h14;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StActive    = 2'd1,
        StReleasing = 2'd2,
        StFinished  = 2'd3
    } voice_state_e;

    voice_state_e         state_q   [NUM_VOICES];
    voice_state_e         state_d   [NUM_VOICES];
    logic [CntW-1:0]      rel_cnt_q [NUM_VOICES];
    logic [CntW-1:0]      rel_cnt_d [NUM_VOICES];
    logic [FCW_WIDTH-1:0] fcw_q     [NUM_VOICES];
    logic [FCW_WIDTH-1:0] fcw_d     [NUM_VOICES];

    logic [NUM_VOICES-1:0] fin_flag_q, fin_flag_d;
    logic [NUM_VOICES-1:0] note_start_q, note_start_d;
    logic [NUM_VOICES-1:0] note_release_q, note_release_d;
    logic [NUM_VOICES-1:0] note_reset_q, note_reset_d;
    logic                  synth_rst_q, synth_rst_d;
    logic [31:0]           cycle_cnt_q, cycle_cnt_d;
    logic [31:0]           inst_cnt_q, inst_cnt_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;

    logic                  load, store, voice_hit;
    logic [2:0]            voice_idx;
    logic [4:0]            voice_off;
    logic [31:0]           load_val;
    logic [NUM_VOICES-1:0] voice_sel, expiring;
    logic [NUM_VOICES-1:0] wr_fcw, wr_start, wr_release, wr_reset, rd_fin;
    logic                  unused_wdata;

    assign unused_wdata = ^wdata;

    always_comb begin
        load      = en && (mmap_sel == 3'd1);
        store     = en && (mmap_sel == 3'd2);
        voice_idx = addr[7:5];
        voice_off = addr[4:0];
        voice_hit = (addr[15:8] == 8'h10) && (32'(voice_idx) < NUM_VOICES);
    end

    // Per-voice access strobes; expiring marks the last cycle of a release.
    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            voice_sel[v]  = voice_hit && (voice_idx == 3'(v));
            wr_fcw[v]     = store && voice_sel[v] && (voice_off == OffFcw);
            wr_start[v]   = store && voice_sel[v] && (voice_off == OffStart);
            wr_release[v] = store && voice_sel[v] && (voice_off == OffRelease);
            wr_reset[v]   = store && voice_sel[v] && (voice_off == OffReset);
            rd_fin[v]     = load && voice_sel[v] && (voice_off == OffFinished);
            expiring[v]   = (state_q[v] == StReleasing) && (rel_cnt_q[v] == '0);
        end
    end

    always_comb begin
        load_val = '0;
        if (addr == AddrCycle) begin
            load_val = cycle_cnt_q;
        end else if (addr == AddrInst) begin
            load_val = inst_cnt_q;
        end
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (voice_sel[v]) begin
                case (voice_off)
                    OffFcw:      load_val = 32'(fcw_q[v]);
                    // A flag being set this very cycle reads as 0 and survives for the next read.
                    OffFinished: load_val = {31'b0, fin_flag_q[v] & ~expiring[v]};
                    OffState:    load_val = {30'b0, state_q[v]};
                    default:     load_val = '0;
                endcase
            end
        end
    end

    always_comb begin
        cycle_cnt_d    = cycle_cnt_q + 32'd1;
        inst_cnt_d     = inst_cnt_q + {31'b0, inst_inc};
        rvalid_d       = load;
        rdata_d        = load ? load_val : rdata_q;
        synth_rst_d    = 1'b0;
        note_start_d   = '0;
        note_release_d = '0;
        note_reset_d   = '0;
        fin_flag_d     = fin_flag_q;
        for (int v = 0; v < NUM_VOICES; v++) begin
            state_d[v]   = state_q[v];
            rel_cnt_d[v] = rel_cnt_q[v];
            fcw_d[v]     = fcw_q[v];
        end

        if (store && (addr == AddrCntClr)) begin
            cycle_cnt_d = '0;
            inst_cnt_d  = '0;
        end

        for (int v = 0; v < NUM_VOICES; v++) begin
            if (rd_fin[v]) begin
                fin_flag_d[v] = 1'b0;
            end
            if (wr_fcw[v]) begin
                fcw_d[v] = wdata[FCW_WIDTH-1:0];
            end
            // Explicit commands take priority over a release expiring in the same cycle.
            if (wr_start[v]) begin
                state_d[v]      = StActive;
                rel_cnt_d[v]    = '0;
                note_start_d[v] = 1'b1;
            end else if (wr_release[v] && (state_q[v] == StActive)) begin
                state_d[v]        = StReleasing;
                rel_cnt_d[v]      = CntLoad;
                note_release_d[v] = 1'b1;
            end else if (wr_reset[v]) begin
                state_d[v]      = StIdle;
                rel_cnt_d[v]    = '0;
                fin_flag_d[v]   = 1'b0;
                note_reset_d[v] = 1'b1;
            end else if (state_q[v] == StReleasing) begin
                if (expiring[v]) begin
                    state_d[v]    = StFinished;
                    fin_flag_d[v] = 1'b1;
                end else begin
                    rel_cnt_d[v] = rel_cnt_q[v] - CntW'(1);
                end
            end
        end

        if (store && (addr == AddrSynthRst)) begin
            synth_rst_d = 1'b1;
            fin_flag_d  = '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                state_d[v]   = StIdle;
                rel_cnt_d[v] = '0;
                fcw_d[v]     = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fin_flag_q     <= '0;
            note_start_q   <= '0;
            note_release_q <= '0;
            note_reset_q   <= '0;
            synth_rst_q    <= 1'b0;
            cycle_cnt_q    <= '0;
            inst_cnt_q     <= '0;
            rdata_q        <= '0;
            rvalid_q       <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                state_q[v]   <= StIdle;
                rel_cnt_q[v] <= '0;
                fcw_q[v]     <= '0;
            end
        end else begin
            fin_flag_q     <= fin_flag_d;
            note_start_q   <= note_start_d;
            note_release_q <= note_release_d;
            note_reset_q   <= note_reset_d;
            synth_rst_q    <= synth_rst_d;
            cycle_cnt_q    <= cycle_cnt_d;
            inst_cnt_q     <= inst_cnt_d;
            rdata_q        <= rdata_d;
            rvalid_q       <= rvalid_d;
            for (int v = 0; v < NUM_VOICES; v++) begin
                state_q[v]   <= state_d[v];
                rel_cnt_q[v] <= rel_cnt_d[v];
                fcw_q[v]     <= fcw_d[v];
            end
        end
    end

    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            fcw[v*FCW_WIDTH +: FCW_WIDTH] = fcw_q[v];
            voice_active[v] = (state_q[v] == StActive) || (state_q[v] == StReleasing);
        end
    end

    assign rdata        = rdata_q;
    assign rvalid       = rvalid_q;
    assign note_start   = note_start_q;
    assign note_release = note_release_q;
    assign note_reset   = note_reset_q;
    assign synth_rst    = synth_rst_q;

endmodule

// File: tb/tb_mmio_voice_ctrl.sv
// Bench for mmio_voice_ctrl: directed scenarios plus random bus traffic, every cycle compared
// against an event-level model (release expiry tracked as an absolute finishing edge number).
module tb_mmio_voice_ctrl;

    localparam int NV = 4;
    localparam int FW = 24;
    localparam int RC = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [15:0]       addr;
    logic [2:0]        mmap_sel;
    logic [31:0]       wdata;
    logic              inst_inc;
    logic [31:0]       rdata;
    logic              rvalid;
    logic [NV*FW-1:0]  fcw;
    logic [NV-1:0]     note_start, note_release, note_reset, voice_active;
    logic              synth_rst;

    mmio_voice_ctrl #(
        .NUM_VOICES    (NV),
        .FCW_WIDTH     (FW),
        .RELEASE_CYCLES(RC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .addr        (addr),
        .mmap_sel    (mmap_sel),
        .wdata       (wdata),
        .inst_inc    (inst_inc),
        .rdata       (rdata),
        .rvalid      (rvalid),
        .fcw         (fcw),
        .note_start  (note_start),
        .note_release(note_release),
        .note_reset  (note_reset),
        .voice_active(voice_active),
        .synth_rst   (synth_rst)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model state (values visible after the most recent edge).
    int            m_state [NV];
    int            m_fin   [NV];
    bit            m_flag  [NV];
    logic [FW-1:0] m_fcw   [NV];
    logic [31:0]   m_cyc, m_inst, m_rdata;
    bit            m_rvalid, m_srst;
    logic [NV-1:0] m_ns, m_nr, m_nx;
    int            edge_n = 0;

    task automatic model_edge();
        bit          rd, wr, vhit;
        int          vi;
        logic [4:0]  off;
        bit          cmd     [NV];
        bit          exp_now [NV];
        logic [31:0] nc, ni;
        edge_n++;
        m_ns = '0; m_nr = '0; m_nx = '0; m_srst = 1'b0;
        if (!rst_n) begin
            m_rdata = '0; m_rvalid = 1'b0; m_cyc = '0; m_inst = '0;
            for (int v = 0; v < NV; v++) begin
                m_state[v] = 0; m_flag[v] = 1'b0; m_fcw[v] = '0; m_fin[v] = 0;
            end
            return;
        end
        rd   = en && (mmap_sel == 3'd1);
        wr   = en && (mmap_sel == 3'd2);
        vi   = int'(addr[7:5]);
        off  = addr[4:0];
        vhit = (addr[15:8] == 8'h10) && (vi < NV);
        for (int v = 0; v < NV; v++) begin
            cmd[v] = (wr && vhit && vi == v && (off == 5'h04 || off == 5'h10))
                     || (wr && addr == 16'h0100);
            exp_now[v] = (m_state[v] == 2) && (m_fin[v] == edge_n) && !cmd[v];
        end
        m_rvalid = rd;
        if (rd) begin
            m_rdata = '0;
            if (addr == 16'h0010) m_rdata = m_cyc;
            else if (addr == 16'h0014) m_rdata = m_inst;
            else if (vhit) begin
                case (off)
                    5'h00: m_rdata = 32'(m_fcw[vi]);
                    5'h0C: begin
                        m_rdata = 32'(m_flag[vi] && !exp_now[vi]);
                        m_flag[vi] = 1'b0;
                    end
                    5'h14: m_rdata = 32'(m_state[vi]);
                    default: m_rdata = '0;
                endcase
            end
        end
        nc = m_cyc + 32'd1;
        ni = m_inst + 32'(inst_inc);
        for (int v = 0; v < NV; v++) begin
            if (exp_now[v]) begin
                m_state[v] = 3; m_flag[v] = 1'b1;
            end
        end
        if (wr) begin
            if (addr == 16'h0018) begin
                nc = '0; ni = '0;
            end
            if (addr == 16'h0100) begin
                m_srst = 1'b1;
                for (int v = 0; v < NV; v++) begin
                    m_state[v] = 0; m_fcw[v] = '0; m_flag[v] = 1'b0;
                end
            end
            if (vhit) begin
                case (off)
                    5'h00: m_fcw[vi] = wdata[FW-1:0];
                    5'h04: begin m_state[vi] = 1; m_ns[vi] = 1'b1; end
                    5'h08: if (m_state[vi] == 1) begin
                        m_state[vi] = 2; m_fin[vi] = edge_n + RC; m_nr[vi] = 1'b1;
                    end
                    5'h10: begin m_state[vi] = 0; m_flag[vi] = 1'b0; m_nx[vi] = 1'b1; end
                    default: ;
                endcase
            end
        end
        m_cyc  = nc;
        m_inst = ni;
    endtask

    task automatic check_outputs();
        logic [NV-1:0] act;
        for (int v = 0; v < NV; v++) act[v] = (m_state[v] == 1) || (m_state[v] == 2);
        check_eq("rvalid", 32'(rvalid), 32'(m_rvalid));
        check_eq("rdata", rdata, m_rdata);
        check_eq("pulses", 32'({note_start, note_release, note_reset, synth_rst}),
                 32'({m_ns, m_nr, m_nx, m_srst}));
        check_eq("voice_active", 32'(voice_active), 32'(act));
        for (int v = 0; v < NV; v++) check_eq("fcw", 32'(fcw[v*FW +: FW]), 32'(m_fcw[v]));
    endtask

    // Inputs set by the caller are sampled at the next rising edge, then cleared.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
        en = 1'b0; mmap_sel = 3'd0; inst_inc = 1'b0;
    endtask

    task automatic ld(input logic [15:0] a);
        en = 1'b1; mmap_sel = 3'd1; addr = a; step();
    endtask

    task automatic st(input logic [15:0] a, input logic [31:0] d);
        en = 1'b1; mmap_sel = 3'd2; addr = a; wdata = d; step();
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    logic [4:0]  offs [8] = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h18, 5'h1C};
    logic [15:0] glob [6] = '{16'h0010, 16'h0014, 16'h0018, 16'h0100, 16'h0000, 16'h2000};

    initial begin
        rst_n = 1'b0; en = 1'b0; mmap_sel = 3'd0; addr = '0; wdata = '0; inst_inc = 1'b0;
        idle(2);
        check_eq("rst_rdata", rdata, 32'h0);
        check_eq("rst_active", 32'(voice_active), 32'h0);
        rst_n = 1'b1;
        idle(2);

        // FCW store/load round trip on voice 1
        st(16'h1020, 32'hFF_ABCDEF);
        ld(16'h1020);
        check_eq("fcw_rd_valid", 32'(rvalid), 32'h1);
        check_eq("fcw_rd_data", rdata, 32'h00AB_CDEF);
        idle(1);
        check_eq("rvalid_drop", 32'(rvalid), 32'h0);
        check_eq("rdata_hold", rdata, 32'h00AB_CDEF);

        // Full release on voice 0
        st(16'h1004, 32'h0);
        st(16'h1008, 32'h0);
        check_eq("rel_pulse", 32'(note_release), 32'h1);
        for (int i = 0; i < RC; i++) begin
            ld(16'h1014);
            check_eq("rel_state", rdata, 32'd2);
        end
        ld(16'h1014);
        check_eq("fin_state", rdata, 32'd3);
        ld(16'h100C);
        check_eq("fin_flag1", rdata, 32'd1);
        ld(16'h100C);
        check_eq("fin_flag2", rdata, 32'd0);

        // Retrigger during release
        st(16'h1004, 32'h0);
        st(16'h1008, 32'h0);
        idle(2);
        st(16'h1004, 32'h0);
        check_eq("retrig_pulse", 32'(note_start), 32'h1);
        ld(16'h1014);
        check_eq("retrig_state", rdata, 32'd1);
        idle(RC + 2);
        ld(16'h100C);
        check_eq("retrig_flag", rdata, 32'd0);

        // Release from idle and out-of-range voice
        st(16'h1030, 32'h0);
        st(16'h1028, 32'h0);
        check_eq("idle_rel_pulse", 32'(note_release), 32'h0);
        ld(16'h1034);
        check_eq("idle_state", rdata, 32'd0);
        st(16'h10A0, 32'h1234);
        ld(16'h10A0);
        check_eq("oob_voice", rdata, 32'd0);

        // Global synth reset with all voices playing
        for (int v = 0; v < NV; v++) begin
            st(16'(16'h1000 + 32 * v), 32'(v + 7));
            st(16'(16'h1004 + 32 * v), 32'h0);
        end
        check_eq("all_active", 32'(voice_active), 32'hF);
        st(16'h0100, 32'h0);
        check_eq("srst_pulse", 32'(synth_rst), 32'h1);
        check_eq("srst_active", 32'(voice_active), 32'h0);
        check_eq("srst_fcw", 32'(|fcw), 32'h0);
        check_eq("srst_no_nreset", 32'(note_reset), 32'h0);
        idle(1);
        check_eq("srst_width", 32'(synth_rst), 32'h0);

        // Counter clear beats increment
        idle(5);
        inst_inc = 1'b1;
        st(16'h0018, 32'h0);
        ld(16'h0010);
        check_eq("cyc_small", 32'(rdata < 32'd4), 32'h1);
        ld(16'h0014);
        check_eq("inst_zero", rdata, 32'd0);

        // Reset in the middle of a release
        st(16'h1044, 32'h0);
        st(16'h1048, 32'h0);
        idle(1);
        rst_n = 1'b0;
        step();
        check_eq("mid_rst_rdata", rdata, 32'h0);
        check_eq("mid_rst_rvalid", 32'(rvalid), 32'h0);
        check_eq("mid_rst_active", 32'(voice_active), 32'h0);
        rst_n = 1'b1;
        idle(RC + 3);
        ld(16'h104C);
        check_eq("mid_rst_flag", rdata, 32'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            inst_inc = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) >= 35) begin
                if ($urandom_range(0, 15) < 12) begin
                    int v;
                    v = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 7))
                                                     : int'($urandom_range(0, 3));
                    addr = 16'(16'h1000 + 32 * v) | 16'(offs[$urandom_range(0, 7)]);
                end else begin
                    addr = glob[$urandom_range(0, 5)];
                end
                wdata    = $urandom;
                en       = ($urandom_range(0, 9) != 0);
                mmap_sel = 3'($urandom_range(0, 9) < 9 ? $urandom_range(1, 2)
                                                       : $urandom_range(3, 7));
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
